// File: rtl/biriscv_div_scheduler.sv
// Shares one iterative divider between both issue slots; accept -> div_valid_o next cycle, wb one cycle after div_done_i.
// Requests wait (ready low) while an op is outstanding; flush kills it. `DIV_SCHED_ZERO_BYPASS_EN` answers rb==0 locally.
module biriscv_div_scheduler #(
  parameter int MAX_DIV_CYCLES = 34
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  input  logic [31:0] req0_opcode_i,
  input  logic [31:0] req0_ra_i,
  input  logic [31:0] req0_rb_i,
  input  logic [4:0]  req0_rd_idx_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [31:0] req1_opcode_i,
  input  logic [31:0] req1_ra_i,
  input  logic [31:0] req1_rb_i,
  input  logic [4:0]  req1_rd_idx_i,
  output logic        req1_ready_o,
  input  logic        flush_i,
  output logic        div_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_ra_o,
  output logic [31:0] div_rb_o,
  input  logic        div_done_i,
  input  logic [31:0] div_result_i,
  output logic        wb_valid_o,
  output logic        wb_slot_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_DIV_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_BYPASS
  } state_t;

  state_t        state, state_nxt;
  logic          rr_ptr;
  logic [31:0]   opcode_q, ra_q, rb_q, result_q;
  logic [4:0]    rd_q;
  logic          slot_q;
  logic [CW-1:0] cnt;
  logic          wb_q, err_q;

  logic          gnt0, gnt1, accept, timeout, wb_set, err_set, to_bypass;
  logic [31:0]   sel_opcode, sel_ra, sel_rb;
  logic [4:0]    sel_rd;

  // Round-robin only matters when both slots ask; a lone request always wins.
  assign gnt0 = req0_valid_i & (~req1_valid_i | ~rr_ptr);
  assign gnt1 = req1_valid_i & (~req0_valid_i | rr_ptr);

  assign req0_ready_o = (state == S_IDLE) & gnt0 & ~flush_i;
  assign req1_ready_o = (state == S_IDLE) & gnt1 & ~flush_i;
  assign accept       = req0_ready_o | req1_ready_o;

  assign sel_opcode = gnt1 ? req1_opcode_i : req0_opcode_i;
  assign sel_ra     = gnt1 ? req1_ra_i     : req0_ra_i;
  assign sel_rb     = gnt1 ? req1_rb_i     : req0_rb_i;
  assign sel_rd     = gnt1 ? req1_rd_idx_i : req0_rd_idx_i;

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  assign to_bypass = accept & (sel_rb == 32'd0);
`else
  assign to_bypass = 1'b0;
`endif

  assign timeout = (cnt == CW'(MAX_DIV_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    wb_set    = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = to_bypass ? S_BYPASS : S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = flush_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        // A result arriving with flush is simply dropped; nothing is left in flight.
        if (div_done_i) begin
          state_nxt = S_IDLE;
          wb_set    = ~flush_i;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end else if (flush_i) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_done_i) begin
          state_nxt = S_IDLE;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_set   = 1'b1;
        end
      end
      S_BYPASS: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      rr_ptr   <= 1'b0;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      slot_q   <= 1'b0;
      result_q <= '0;
      cnt      <= '0;
      wb_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      wb_q  <= wb_set;
      if (err_set) err_q <= 1'b1;
      if (accept) begin
        rr_ptr   <= ~gnt1;
        opcode_q <= sel_opcode;
        ra_q     <= sel_ra;
        rb_q     <= sel_rb;
        rd_q     <= sel_rd;
        slot_q   <= gnt1;
        cnt      <= '0;
      end else if ((state == S_WAIT) || (state == S_DRAIN)) begin
        cnt <= cnt + 1'b1;
      end
      if (wb_set) begin
        result_q <= div_result_i;
      end else if (to_bypass) begin
        // funct3[1] distinguishes REM/REMU (remainder = dividend) from DIV/DIVU (all ones).
        result_q <= sel_opcode[13] ? sel_ra : 32'hFFFF_FFFF;
      end
    end
  end

  assign div_valid_o  = (state == S_ISSUE) & ~flush_i;
  assign div_opcode_o = opcode_q;
  assign div_ra_o     = ra_q;
  assign div_rb_o     = rb_q;

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  assign wb_valid_o = wb_q | ((state == S_BYPASS) & ~flush_i);
`else
  assign wb_valid_o = wb_q;
`endif
  assign wb_slot_o   = slot_q;
  assign wb_rd_idx_o = rd_q;
  assign wb_value_o  = result_q;
  assign busy_o      = (state != S_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_biriscv_div_scheduler.sv
// Randomized and directed bench for the divider scheduler; the bench itself plays the divider.
module tb_biriscv_div_scheduler;
  localparam int MAX = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_v, r1_v, r0_rdy, r1_rdy;
  logic [31:0] r0_op, r0_ra, r0_rb, r1_op, r1_ra, r1_rb;
  logic [4:0]  r0_rd, r1_rd;
  logic        flush, div_v, done, wb_v, wb_slot, busy, err;
  logic [31:0] div_op, div_ra, div_rb, result, wb_val;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  biriscv_div_scheduler #(.MAX_DIV_CYCLES(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(r0_v), .req0_opcode_i(r0_op), .req0_ra_i(r0_ra), .req0_rb_i(r0_rb),
    .req0_rd_idx_i(r0_rd), .req0_ready_o(r0_rdy),
    .req1_valid_i(r1_v), .req1_opcode_i(r1_op), .req1_ra_i(r1_ra), .req1_rb_i(r1_rb),
    .req1_rd_idx_i(r1_rd), .req1_ready_o(r1_rdy),
    .flush_i(flush),
    .div_valid_o(div_v), .div_opcode_o(div_op), .div_ra_o(div_ra), .div_rb_o(div_rb),
    .div_done_i(done), .div_result_i(result),
    .wb_valid_o(wb_v), .wb_slot_o(wb_slot), .wb_rd_idx_o(wb_rd), .wb_value_o(wb_val),
    .busy_o(busy), .err_o(err)
  );

  function automatic logic [31:0] mk_op(input logic [2:0] f3, input logic [4:0] rd);
    logic [4:0] rs1, rs2;
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    return {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // RISC-V M-extension division results, including the divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    r0_v = 0; r1_v = 0; flush = 0; done = 0; result = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    r0_op = '0; r0_ra = '0; r0_rb = '0; r0_rd = '0;
    r1_op = '0; r1_ra = '0; r1_rb = '0; r1_rd = '0;
    rst_n = 0;
    @(negedge clk);
    checks++; if ({busy, div_v, wb_v, err, r0_rdy, r1_rdy} !== 6'b0) begin errors++;
      $display("FAIL reset_outputs: got %b want 000000", {busy, div_v, wb_v, err, r0_rdy, r1_rdy}); end
    tick();
    rst_n = 1;
    tick();
    r0_v = 1; r0_op = mk_op(3'd5, 5'd3); r0_ra = 32'd77; r0_rb = 32'd4; r0_rd = 5'd3;
    tick();
    r0_v = 0;
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    tick();
    rst_n = 0;
    #1;
    checks++; if ({busy, div_v, wb_v, err} !== 4'b0 || div_ra !== 32'd0 || div_rb !== 32'd0 || wb_val !== 32'd0) begin
      errors++; $display("FAIL reset_mid_wait: got busy/div/wb/err=%b ra=%0h rb=%0h val=%0h want all 0",
                         {busy, div_v, wb_v, err}, div_ra, div_rb, wb_val); end
    tick();
    rst_n = 1;
    tick();
    done = 1; result = 32'd19;
    @(negedge clk);
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL reset_late_done_same: got wb=%b want 0", wb_v); end
    tick();
    done = 0;
    @(negedge clk);
    checks++; if (wb_v !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_late_done: got wb=%b busy=%b want 0 0", wb_v, busy); end
  endtask

  task automatic test_basic;
    logic [31:0] op;
    do_reset();
    op = mk_op(3'd5, 5'd9);
    r0_v = 1; r0_op = op; r0_ra = 32'd100; r0_rb = 32'd7; r0_rd = 5'd9;
    @(negedge clk);
    checks++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0 || div_v !== 1'b0) begin errors++;
      $display("FAIL basic_accept: got rdy0=%b rdy1=%b div=%b want 1 0 0", r0_rdy, r1_rdy, div_v); end
    tick();
    r0_v = 0;
    @(negedge clk);
    checks++; if (div_v !== 1'b1 || div_ra !== 32'd100 || div_rb !== 32'd7 || div_op !== op) begin errors++;
      $display("FAIL basic_issue: got v=%b ra=%0d rb=%0d op=%h want 1 100 7 %h", div_v, div_ra, div_rb, div_op, op); end
    for (int i = 1; i < 5; i++) begin
      tick();
      @(negedge clk);
      checks++; if (div_v !== 1'b0 || wb_v !== 1'b0 || busy !== 1'b1) begin errors++;
        $display("FAIL basic_wait%0d: got div=%b wb=%b busy=%b want 0 0 1", i, div_v, wb_v, busy); end
    end
    tick();
    done = 1; result = 32'd14;
    @(negedge clk);
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL basic_done_cycle: got wb=%b want 0", wb_v); end
    tick();
    done = 0; result = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (wb_v !== 1'b1 || wb_slot !== 1'b0 || wb_rd !== 5'd9 || wb_val !== 32'd14 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_wb: got v=%b slot=%b rd=%0d val=%0d busy=%b want 1 0 9 14 0",
                         wb_v, wb_slot, wb_rd, wb_val, busy); end
    tick();
    @(negedge clk);
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL basic_wb_pulse: got wb=%b want 0", wb_v); end
  endtask

  task automatic test_arbitration;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      r0_v = 1; r0_op = mk_op(3'd5, 5'd1); r0_ra = 32'd50 + 32'(r); r0_rb = 32'd5; r0_rd = 5'd1;
      r1_v = 1; r1_op = mk_op(3'd7, 5'd2); r1_ra = 32'd99; r1_rb = 32'd3; r1_rd = 5'd2;
      @(negedge clk);
      checks++; if (r0_rdy !== (r == 0) || r1_rdy !== (r == 1)) begin errors++;
        $display("FAIL arb_grant%0d: got rdy0=%b rdy1=%b want %b %b", r, r0_rdy, r1_rdy, r == 0, r == 1); end
      tick();
      r0_v = 0; r1_v = 0;
      @(negedge clk);
      checks++; if (div_v !== 1'b1 || div_ra !== ((r == 0) ? 32'd50 : 32'd99)) begin errors++;
        $display("FAIL arb_issue%0d: got v=%b ra=%0d", r, div_v, div_ra); end
      tick();
      done = 1; result = 32'h1234 + 32'(r);
      tick();
      done = 0;
      @(negedge clk);
      checks++; if (wb_v !== 1'b1 || wb_slot !== 1'(r) || wb_rd !== 5'(r + 1) || wb_val !== 32'h1234 + 32'(r)) begin
        errors++; $display("FAIL arb_wb%0d: got v=%b slot=%b rd=%0d val=%h", r, wb_v, wb_slot, wb_rd, wb_val); end
      tick();
    end
  endtask

  task automatic test_flush;
    do_reset();
    r1_v = 1; r1_op = mk_op(3'd4, 5'd4); r1_ra = 32'd8; r1_rb = 32'd2; r1_rd = 5'd4; flush = 1;
    @(negedge clk);
    checks++; if (r1_rdy !== 1'b0 || r0_rdy !== 1'b0) begin errors++;
      $display("FAIL flush_idle_ready: got rdy0=%b rdy1=%b want 0 0", r0_rdy, r1_rdy); end
    tick();
    flush = 0;
    @(negedge clk);
    checks++; if (r1_rdy !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL flush_idle_noaccept: got rdy1=%b busy=%b want 1 0", r1_rdy, busy); end
    tick();
    r1_v = 0; flush = 1;
    @(negedge clk);
    checks++; if (div_v !== 1'b0) begin errors++; $display("FAIL flush_issue_div: got %b want 0", div_v); end
    tick();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || div_v !== 1'b0 || wb_v !== 1'b0) begin errors++;
        $display("FAIL flush_issue_idle%0d: got busy=%b div=%b wb=%b want 0 0 0", i, busy, div_v, wb_v); end
      tick();
    end
    r0_v = 1; r0_op = mk_op(3'd6, 5'd6); r0_ra = 32'd20; r0_rb = 32'd6; r0_rd = 5'd6;
    tick();
    r0_v = 0;
    @(negedge clk);
    checks++; if (div_v !== 1'b1) begin errors++; $display("FAIL flush_wait_issue: got %b want 1", div_v); end
    tick();
    flush = 1;
    tick();
    flush = 0;
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_drain_busy: got %b want 1", busy); end
    tick();
    done = 1; result = 32'd2;
    @(negedge clk);
    checks++; if (wb_v !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL flush_drain_done: got wb=%b busy=%b want 0 1", wb_v, busy); end
    tick();
    done = 0;
    @(negedge clk);
    checks++; if (wb_v !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL flush_drain_after: got wb=%b busy=%b want 0 0", wb_v, busy); end
  endtask

  task automatic test_watchdog;
    int first;
    int wb_seen;
    do_reset();
    r1_v = 1; r1_op = mk_op(3'd5, 5'd11); r1_ra = 32'd1000; r1_rb = 32'd3; r1_rd = 5'd11;
    tick();
    r1_v = 0;
    first = 0;
    wb_seen = 0;
    for (int k = 1; k <= MAX + 6 && first == 0; k++) begin
      tick();
      @(negedge clk);
      if (wb_v) wb_seen++;
      if (err) first = k;
    end
    checks++; if (first != MAX + 1) begin errors++;
      $display("FAIL watchdog_time: got err after %0d wait cycles want %0d", first - 1, MAX); end
    checks++; if (busy !== 1'b0 || wb_seen != 0) begin errors++;
      $display("FAIL watchdog_idle: got busy=%b wb_count=%0d want 0 0", busy, wb_seen); end
    tick();
    r0_v = 1; r0_op = mk_op(3'd5, 5'd12); r0_ra = 32'd30; r0_rb = 32'd3; r0_rd = 5'd12;
    @(negedge clk);
    checks++; if (r0_rdy !== 1'b1) begin errors++; $display("FAIL watchdog_reaccept: got %b want 1", r0_rdy); end
    tick();
    r0_v = 0;
    tick();
    done = 1; result = 32'd10;
    tick();
    done = 0;
    @(negedge clk);
    checks++; if (wb_v !== 1'b1 || wb_val !== 32'd10 || err !== 1'b1) begin errors++;
      $display("FAIL watchdog_after: got wb=%b val=%0d err=%b want 1 10 1", wb_v, wb_val, err); end
    tick();
  endtask

  task automatic test_div_zero;
    do_reset();
    r0_v = 1; r0_op = mk_op(3'd6, 5'd7); r0_ra = 32'd5; r0_rb = 32'd0; r0_rd = 5'd7;
    tick();
    r0_v = 0;
    @(negedge clk);
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    checks++; if (div_v !== 1'b0 || wb_v !== 1'b1 || wb_val !== 32'd5 || wb_rd !== 5'd7) begin errors++;
      $display("FAIL bypass_rem: got div=%b wb=%b val=%h rd=%0d want 0 1 5 7", div_v, wb_v, wb_val, wb_rd); end
    tick();
    r1_v = 1; r1_op = mk_op(3'd4, 5'd8); r1_ra = 32'd5; r1_rb = 32'd0; r1_rd = 5'd8;
    tick();
    r1_v = 0;
    @(negedge clk);
    checks++; if (div_v !== 1'b0 || wb_v !== 1'b1 || wb_val !== 32'hFFFF_FFFF || wb_slot !== 1'b1) begin errors++;
      $display("FAIL bypass_div: got div=%b wb=%b val=%h slot=%b want 0 1 ffffffff 1", div_v, wb_v, wb_val, wb_slot); end
    tick();
    r0_v = 1; r0_rb = 32'd0;
    tick();
    r0_v = 0; flush = 1;
    @(negedge clk);
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL bypass_flush: got wb=%b want 0", wb_v); end
    tick();
    flush = 0;
    @(negedge clk);
    checks++; if (wb_v !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL bypass_flush_after: got wb=%b busy=%b want 0 0", wb_v, busy); end
`else
    checks++; if (div_v !== 1'b1 || div_rb !== 32'd0 || wb_v !== 1'b0) begin errors++;
      $display("FAIL zero_via_divider: got div=%b rb=%0d wb=%b want 1 0 0", div_v, div_rb, wb_v); end
    tick();
    done = 1; result = ref_div(3'd6, 32'd5, 32'd0);
    tick();
    done = 0;
    @(negedge clk);
    checks++; if (wb_v !== 1'b1 || wb_val !== 32'd5) begin errors++;
      $display("FAIL zero_wb: got wb=%b val=%h want 1 5", wb_v, wb_val); end
`endif
    tick();
  endtask

  task automatic test_random;
    logic        rr, g, v0, v1;
    logic [2:0]  f3 [2];
    logic [31:0] ra [2], rb [2], op [2];
    logic [4:0]  rd [2];
    int          d;
    do_reset();
    rr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      for (int s = 0; s < 2; s++) begin
        f3[s] = 3'($urandom_range(4, 7));
        rd[s] = 5'($urandom);
        ra[s] = $urandom;
        rb[s] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
        if ($urandom_range(0, 7) == 0) begin ra[s] = 32'h8000_0000; rb[s] = 32'hFFFF_FFFF; end
`ifdef DIV_SCHED_ZERO_BYPASS_EN
        if (rb[s] == 0) rb[s] = 32'd1;
`endif
        op[s] = mk_op(f3[s], rd[s]);
      end
      g = (v0 && v1) ? rr : !v0;
      r0_v = v0; r0_op = op[0]; r0_ra = ra[0]; r0_rb = rb[0]; r0_rd = rd[0];
      r1_v = v1; r1_op = op[1]; r1_ra = ra[1]; r1_rb = rb[1]; r1_rd = rd[1];
      @(negedge clk);
      checks++; if (r0_rdy !== !g || r1_rdy !== g) begin errors++;
        $display("FAIL rand%0d_grant: got rdy0=%b rdy1=%b want %b %b", n, r0_rdy, r1_rdy, !g, g); end
      rr = !g;
      tick();
      r0_v = 0; r1_v = 0;
      @(negedge clk);
      checks++; if (div_v !== 1'b1 || div_op !== op[g] || div_ra !== ra[g] || div_rb !== rb[g]) begin errors++;
        $display("FAIL rand%0d_issue: got v=%b op=%h ra=%h rb=%h want 1 %h %h %h",
                 n, div_v, div_op, div_ra, div_rb, op[g], ra[g], rb[g]); end
      d = $urandom_range(0, 5);
      r0_v = 1; r1_v = 1;
      for (int i = 0; i < d; i++) begin
        tick();
        @(negedge clk);
        checks++; if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0 || wb_v !== 1'b0 || div_v !== 1'b0) begin errors++;
          $display("FAIL rand%0d_busy: got rdy=%b%b wb=%b div=%b want 00 0 0", n, r0_rdy, r1_rdy, wb_v, div_v); end
      end
      tick();
      r0_v = 0; r1_v = 0;
      done = 1; result = ref_div(f3[g], ra[g], rb[g]);
      tick();
      done = 0; result = $urandom;
      @(negedge clk);
      checks++; if (wb_v !== 1'b1 || wb_slot !== g || wb_rd !== rd[g] || wb_val !== ref_div(f3[g], ra[g], rb[g])) begin
        errors++; $display("FAIL rand%0d_wb: got v=%b slot=%b rd=%0d val=%h want 1 %b %0d %h",
                           n, wb_v, wb_slot, wb_rd, wb_val, g, rd[g], ref_div(f3[g], ra[g], rb[g])); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_flush();
    test_watchdog();
    test_div_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
